// File: rtl/axis_traffic_packer_if.sv
// axis_traffic_packer_if: AXI4-Stream bundle with source (master) and sink (slave) views
interface axis_traffic_packer_if #(
  parameter int DW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;
  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_traffic_packer.sv
// axis_traffic_packer: packs AXI4-Stream beats into 64-word 512-bit replay blocks; define TRAFFIC_PACKER_GAP_REC_EN to record input idle cycles as empty slots
module axis_traffic_packer #(
  parameter int DWIDTH       = 128,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_traffic_packer_if.slave  s_axis,
  axis_traffic_packer_if.master m_axis,
  input  logic                  flush_i,
  output logic                  keep_err_o,
  output logic [31:0]           blk_cnt_o
);
  localparam int NB = DWIDTH / 8;
  typedef enum logic [1:0] {FILL, META, DATA} state_t;
  state_t            state_q, state_d;
  logic [5:0]        slot_q, slot_d, idx_q, idx_d, rd_idx;
  logic [511:0]      meta_q, meta_d, tdata_q, tdata_d, rd_word;
  logic [DWIDTH-1:0] buf_q [63];
  logic [DWIDTH-1:0] beat;
  logic [NB-1:0]     run;
  logic [6:0]        n;
  logic [31:0]       idle_q, idle_d, blk_q, blk_d;
  logic              rdy_q, tvalid_q, tvalid_d, tlast_q, tlast_d, err_q, err_d;
  logic              on, hs, gap, wr, fl, to, m_hs;
  // Leading tkeep run gives the byte count; bytes outside it are zeroed and the beat is byte-reversed
  always_comb begin
    on   = 1'b1;
    n    = '0;
    run  = '0;
    beat = '0;
    for (int j = NB - 1; j >= 0; j--) begin
      on     = on & s_axis.tkeep[j];
      run[j] = on;
      n      = n + 7'(on);
    end
    for (int i = 0; i < NB; i++)
      beat[8*(NB-1-i) +: 8] = run[NB-1-i] ? s_axis.tdata[8*i +: 8] : 8'h00;
  end
  assign m_hs = tvalid_q & m_axis.tready;
  assign hs   = rdy_q & s_axis.tvalid;
`ifdef TRAFFIC_PACKER_GAP_REC_EN
  assign gap  = rdy_q & ~s_axis.tvalid & (slot_q != 6'd0);
`else
  assign gap  = 1'b0;
`endif
  assign wr   = hs | gap;
  assign to   = (IDLE_TIMEOUT != 0) && (idle_q == 32'(IDLE_TIMEOUT)) && (slot_q != 6'd0);
  assign fl   = rdy_q & ((flush_i & ((slot_q != 6'd0) | hs)) | to);
  assign rd_idx  = (state_q == META) ? 6'd0 : idx_q + 6'd1;
  assign rd_word = (rd_idx < slot_q) ? 512'(buf_q[rd_idx]) << (512 - DWIDTH) : '0;
  // Next state: fill until slot 62 is written or a flush, then the meta word, then 63 data words
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    state_d = ((wr && slot_q == 6'd62) || fl) ? META : FILL;
      META:    state_d = m_hs ? DATA : META;
      DATA:    state_d = (m_hs && idx_q == 6'd62) ? FILL : DATA;
      default: state_d = FILL;
    endcase
  end
  // Next values for slot bookkeeping, meta, the registered output word, counters and error flag
  always_comb begin
    slot_d   = slot_q + 6'(wr);
    idx_d    = idx_q;
    meta_d   = meta_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    blk_d    = blk_q;
    err_d    = err_q | (hs & |(s_axis.tkeep & ~run));
    idle_d   = hs ? '0 : (idle_q == 32'(IDLE_TIMEOUT)) ? idle_q : idle_q + 32'd1;
    if (hs) meta_d[8*slot_q +: 8] = {n, s_axis.tlast};
    if (state_q == FILL && state_d == META) begin
      tvalid_d = 1'b1;
      tdata_d  = meta_d;
    end
    if (state_q == META && m_hs) begin
      idx_d   = '0;
      tdata_d = rd_word;
    end
    if (state_q == DATA && m_hs) begin
      idx_d   = idx_q + 6'd1;
      tdata_d = rd_word;
      tlast_d = (idx_q == 6'd61);
      if (idx_q == 6'd62) begin
        idx_d    = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        blk_d    = blk_q + 32'd1;
        slot_d   = '0;
        meta_d   = '0;
      end
    end
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end
  // Block bookkeeping and registered outputs; reset discards any partial block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      slot_q   <= '0;
      idx_q    <= '0;
      meta_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      idle_q   <= '0;
      blk_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rdy_q    <= (state_d == FILL);
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      meta_q   <= meta_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      idle_q   <= idle_d;
      blk_q    <= blk_d;
      err_q    <= err_d;
    end
  end
  // Slot buffer needs no reset: slots at or beyond slot_q always read as zero
  always_ff @(posedge clk) begin
    if (wr) buf_q[slot_q] <= hs ? beat : '0;
  end
  // Port drive from registered state
  always_comb begin
    s_axis.tready = rdy_q;
    m_axis.tvalid = tvalid_q;
    m_axis.tdata  = tdata_q;
    m_axis.tlast  = tlast_q;
    m_axis.tkeep  = '1;
    keep_err_o    = err_q;
    blk_cnt_o     = blk_q;
  end
endmodule

// File: tb/tb_axis_traffic_packer.sv
// tb_axis_traffic_packer: directed checks of block packing, flush, timeout, back-pressure and reset
module tb_axis_traffic_packer;
`ifdef TRAFFIC_PACKER_GAP_REC_EN
  localparam int GAPS = 3;
`else
  localparam int GAPS = 0;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         keep_err;
  logic [31:0]  blk_cnt;
  int           n_chk = 0;
  int           n_fail = 0;
  logic [511:0] got [64];
  logic [63:0]  lasts;
  int           nw;

  axis_traffic_packer_if #(.DW(128)) s_if ();
  axis_traffic_packer_if #(.DW(512)) m_if ();

  axis_traffic_packer #(.DWIDTH(128), .IDLE_TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
    .flush_i(flush), .keep_err_o(keep_err), .blk_cnt_o(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dat(input int k);
    return {8'(k), 8'(k) ^ 8'h5a, 112'h0d0c0b0a090807060504030201ff};
  endfunction

  // expected stored word: input byte i at bits [511-8i -: 8], lower 384 bits zero
  function automatic logic [511:0] ew(input logic [127:0] d);
    logic [127:0] r;
    r = {<<8{d}};
    return {r, 384'h0};
  endfunction

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int b;
    b = 0;
    @(negedge clk);
    s_if.tdata = d;
    s_if.tkeep = k;
    s_if.tlast = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("send_ready", s_if.tready, 1);
    @(posedge clk);
  endtask

  task automatic stop_in();
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    s_if.tvalid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic recv(input bit rnd);
    int cyc;
    logic stalled, sready, prev_l;
    logic [511:0] prev_d;
    cyc = 0; stalled = 0; sready = 0; prev_l = 0; prev_d = '0;
    nw = 0; lasts = '0;
    while (nw < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("stall_tvalid", m_if.tvalid, 1);
        chk("stall_tdata", m_if.tdata, prev_d);
        chk("stall_tlast", m_if.tlast, prev_l);
      end
      if (m_if.tvalid) sready = sready | s_if.tready;
      m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = m_if.tvalid & ~m_if.tready;
      prev_d = m_if.tdata;
      prev_l = m_if.tlast;
      if (m_if.tvalid && m_if.tready) begin
        got[nw] = m_if.tdata;
        lasts[nw] = m_if.tlast;
        nw++;
      end
    end
    @(negedge clk);
    m_if.tready = 1'b0;
    chk("word_count", nw, 64);
    chk("no_extra_word", m_if.tvalid, 0);
    chk("s_tready_during_emit", sready, 0);
  endtask

  function automatic logic [511:0] or_from(input int first);
    logic [511:0] acc;
    acc = '0;
    for (int w = first; w < 64; w++) acc = acc | got[w];
    return acc;
  endfunction

  initial begin
    logic [511:0] em;
    logic [127:0] d;
    int cyc;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0; s_if.tvalid = 0;
    m_if.tready = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_keep_err", keep_err, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    rst_n = 1'b1;
    #1 chk("rel_s_tready", s_if.tready, 0);
    @(negedge clk);
    chk("s_tready_after_edge", s_if.tready, 1);

    // full block of 63 beats, tlast on the last one
    for (int k = 0; k < 63; k++) send(dat(k), 16'hFFFF, k == 62);
    stop_in();
    chk("t1_meta_latency", m_if.tvalid, 1);
    chk("t1_s_tready_meta", s_if.tready, 0);
    recv(0);
    em = '0;
    for (int k = 0; k < 62; k++) em[8*k +: 8] = 8'h20;
    em[8*62 +: 8] = 8'h21;
    chk("t1_meta", got[0], em);
    for (int k = 0; k < 63; k++) chk($sformatf("t1_data%0d", k), got[k+1], ew(dat(k)));
    chk("t1_tlast", lasts, 64'h8000_0000_0000_0000);
    chk("t1_blk_cnt", blk_cnt, 1);

    // 5 beats then flush
    for (int k = 0; k < 5; k++) send(dat(100 + k), 16'hFFFF, 0);
    pulse_flush();
    chk("t2_meta_latency", m_if.tvalid, 1);
    recv(0);
    em = '0;
    for (int k = 0; k < 5; k++) em[8*k +: 8] = 8'h20;
    chk("t2_meta", got[0], em);
    chk("t2_data4", got[5], ew(dat(104)));
    chk("t2_pad", or_from(6), 0);
    chk("t2_tlast", lasts, 64'h8000_0000_0000_0000);
    chk("t2_blk_cnt", blk_cnt, 2);

    // 12 leading bytes kept: input bytes 12..15 are dropped
    send(dat(7), 16'hFFF0, 0);
    pulse_flush();
    recv(0);
    em = '0;
    em[7:0] = 8'h18;
    chk("t3_meta", got[0], em);
    d = dat(7);
    d[127:96] = '0;
    chk("t3_data", got[1], ew(d));
    chk("t3_keep_err", keep_err, 0);
    chk("t3_blk_cnt", blk_cnt, 3);

    // non-contiguous keep: leading run of 4, error flag set
    send(dat(8), 16'hF0F0, 0);
    pulse_flush();
    chk("t4_keep_err", keep_err, 1);
    recv(0);
    em = '0;
    em[7:0] = 8'h08;
    chk("t4_meta", got[0], em);
    chk("t4_blk_cnt", blk_cnt, 4);

    // full block emitted under random back-pressure
    for (int k = 0; k < 63; k++) send(dat(200 + k), 16'hFFFF, k == 62);
    stop_in();
    recv(1);
    em = '0;
    for (int k = 0; k < 62; k++) em[8*k +: 8] = 8'h20;
    em[8*62 +: 8] = 8'h21;
    chk("t5_meta", got[0], em);
    for (int k = 0; k < 63; k++) chk($sformatf("t5_data%0d", k), got[k+1], ew(dat(200 + k)));
    chk("t5_tlast", lasts, 64'h8000_0000_0000_0000);
    chk("t5_keep_err_sticky", keep_err, 1);
    chk("t5_blk_cnt", blk_cnt, 5);

    // idle timeout flushes a partial block
    send(dat(30), 16'hFFFF, 0);
    send(dat(31), 16'hFFFF, 0);
    stop_in();
    recv(0);
    em = '0;
    em[15:0] = 16'h2020;
    chk("t6_meta", got[0], em);
    chk("t6_data1", got[2], ew(dat(31)));
    chk("t6_pad", or_from(3), 0);
    chk("t6_blk_cnt", blk_cnt, 6);

    // beat, 3 idle cycles, beat, flush
    send(dat(40), 16'hFFFF, 0);
    stop_in();
    @(negedge clk);
    @(negedge clk);
    send(dat(41), 16'hFFFF, 0);
    pulse_flush();
    recv(0);
    em = '0;
    em[7:0] = 8'h20;
    em[8*(1+GAPS) +: 8] = 8'h20;
    chk("t7_meta", got[0], em);
    chk("t7_second", got[2+GAPS], ew(dat(41)));
    chk("t7_blk_cnt", blk_cnt, 7);

    // flush on an empty block is ignored
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("t8_empty_flush", m_if.tvalid, 0);
    chk("t8_s_tready", s_if.tready, 1);
    // flush coinciding with a beat stores the beat first
    send(dat(50), 16'hFFFF, 0);
    @(negedge clk);
    s_if.tdata = dat(51);
    s_if.tkeep = 16'hFFFF;
    s_if.tlast = 1'b1;
    s_if.tvalid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    flush = 1'b0;
    chk("t8_meta_latency", m_if.tvalid, 1);
    recv(0);
    em = '0;
    em[15:0] = 16'h2120;
    chk("t8_meta", got[0], em);
    chk("t8_data1", got[2], ew(dat(51)));
    chk("t8_pad", or_from(3), 0);
    chk("t8_blk_cnt", blk_cnt, 8);

    // reset while data slot 30 is presented
    for (int k = 0; k < 63; k++) send(dat(k), 16'hFFFF, 0);
    stop_in();
    cyc = 0;
    nw = 0;
    while (nw < 31 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      m_if.tready = 1'b1;
      if (m_if.tvalid) nw++;
    end
    @(negedge clk);
    m_if.tready = 1'b0;
    chk("t9_count", nw, 31);
    chk("t9_pre_valid", m_if.tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t9_valid_drop", m_if.tvalid, 0);
    chk("t9_s_tready", s_if.tready, 0);
    chk("t9_blk_cnt_rst", blk_cnt, 0);
    chk("t9_keep_err_rst", keep_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t9_s_tready_back", s_if.tready, 1);
    send(dat(77), 16'hFFFF, 1);
    pulse_flush();
    recv(0);
    em = '0;
    em[7:0] = 8'h21;
    chk("t9_meta", got[0], em);
    chk("t9_data0", got[1], ew(dat(77)));
    chk("t9_pad", or_from(2), 0);
    chk("t9_blk_cnt", blk_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_traffic_packer.md
# axis_traffic_packer

Synthesizable capture-side counterpart of the file-driven stream player: accepts an AXI4-Stream of DWIDTH bits and packs accepted beats into the 512-bit block format the player consumes. Each block is one meta word followed by 63 data words. The output stream lands in on-chip memory or a host DMA so received traffic can be replayed or diffed offline. Sits behind the RIFL RX user interface in loopback and bring-up designs.

## Interface
- DWIDTH, 128: input data width; multiple of 8, 8..512.
- IDLE_TIMEOUT, 1024: cycles without an accepted beat before a partial block is padded and emitted; 0 disables.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DWIDTH  captured data.
- s_axis_tkeep  in  DWIDTH/8  byte enables, contiguous from MSB.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  high only in FILL.
- flush  in  1  single-cycle pulse; pads and emits the current partial block.
- m_axis_tdata  out  512  packed meta/data word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  high on the 64th word of a block.
- m_axis_tready  in  1  downstream ready.
- keep_err  out  1  sticky; a non-contiguous tkeep was seen.
- blk_cnt  out  32  blocks fully emitted; wraps at 2^32.

## Operation
- States: FILL, META, DATA. Slot index is 6 bits (0..62). Each block holds a meta register plus a 63 x DWIDTH buffer.
- FILL: on each s_axis handshake, write slot k:
  - Meta byte k, bits [8k+7:8k]: [7:1] = n, [0] = tlast, where n is the count of consecutive tkeep ones starting from bit DWIDTH/8-1.
  - Data slot: input byte i (bits [8i+7:8i]) is stored at word bits [511-8i -: 8] when tkeep[DWIDTH/8-1-i] is set, otherwise 0.
  - Word bits below 512-DWIDTH are always 0.
  - Meta byte 63 is always 0.
- A beat with tkeep all-zero is stored with n = 0 (slot reads back as empty). A non-contiguous tkeep stores the leading run only and sets keep_err.
- Writing slot 62 moves the block to META on the next cycle.
- Flush condition: flush pulse, or the idle counter reaching IDLE_TIMEOUT, while FILL holds at least one slot.
  - Unused slots are padded: meta 0, data 0. Go to META.
  - A flush on an empty block is ignored.
  - If flush coincides with a beat handshake, the beat is stored first and then the block flushes.
- META: present the meta word. After the handshake go to DATA with idx = 0.
- DATA: present slot idx. idx increments on each handshake. On the idx 62 handshake, m_axis_tlast = 1, blk_cnt increments, the buffer and meta clear, and the block returns to FILL.

## Timing
- Reset values: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, keep_err = 0, blk_cnt = 0, state FILL with slot 0. s_axis_tready rises on the first clk edge after reset deasserts.
- The meta word is valid one cycle after the slot-62 write or after the flush cycle.
- All m_axis outputs are registered. tdata and tlast hold stable while tvalid && !tready.
- With tready held high, a block takes 64 output cycles. There are no bubbles between META and DATA or between data words.
- s_axis_tready is 0 for the whole of META and DATA. Input is back-pressured, never dropped.
- Idle counter: cleared on every handshake and saturates at IDLE_TIMEOUT.
- An rst_n assertion mid-block discards the partial block immediately. m_axis_tvalid drops asynchronously.

## Configuration
- TRAFFIC_PACKER_GAP_REC_EN defined:
  - In FILL with at least one slot already used, every cycle with s_axis_tvalid = 0 consumes a slot (meta 0, data 0). The replayed stream therefore reproduces the input gap timing.
  - Gaps before the first beat of a block are not recorded.
- Not defined: only accepted beats consume slots.

## Test plan
- 63 full beats, tkeep all ones, DWIDTH = 128, tlast on beat 63: meta byte k = 0x20 for k < 62, byte 62 = 0x21, byte 63 = 0x00. Data word k has the beat bytes in bits [511:384] in reversed byte order, lower bits 0. tlast on word 64. blk_cnt = 1.
- 5 beats, then flush pulse: meta bytes 0..4 nonzero, bytes 5..63 = 0. 58 trailing zero data words. 64 words total.
- Beat with tkeep = 0xFFF0 (12 bytes): meta byte = 0x18. The low 4 stored bytes are 0. keep_err stays 0.
- tkeep = 0xF0F0: n = 4 (0x08), keep_err = 1 and sticky until reset.
- m_axis_tready toggled randomly during emission: words are neither lost nor duplicated, tdata is stable while stalled, s_axis_tready = 0 throughout.
- With GAP_REC_EN: beat, 3 idle cycles, beat, then flush: meta bytes 0x20, 0x00, 0x00, 0x00, 0x20, then zeros.
- rst_n asserted at slot 30 of DATA: m_axis_tvalid = 0 at once. After release, the next block starts from slot 0 with a fresh meta word.
